// File: rtl/sample_frame_streamer.sv
// Buffers strobed 8-bit samples in a FIFO and streams them to a UART as framed bytes:
// HEADER, FRAME_LEN samples, and a trailing 8-bit sum when FRAME_CHECKSUM_EN is defined.
module sample_frame_streamer #(
    parameter int          FRAME_LEN  = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [7:0]                      sample_in,
    input  logic                            sample_valid,
    input  logic                            tx_done,
    output logic                            tx_start,
    output logic [7:0]                      tx_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic                            frame_active
);
    // state | meaning
    // IDLE  | waiting for enable and FRAME_LEN buffered samples
    // HDR   | launch header byte
    // SMP   | pop FIFO head and launch it
    // CHK   | launch checksum byte (FRAME_CHECKSUM_EN only)
    // WAIT  | byte in flight, wait for tx_done

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LEN_CNT = CW'(FRAME_LEN);
    localparam logic [IW-1:0] LEN_IDX = IW'(FRAME_LEN);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        SMP  = 3'd2,
        WAIT = 3'd3
`ifdef FRAME_CHECKSUM_EN
        , CHK = 3'd4
`endif
    } state_t;

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, push, pop;
    logic [IW-1:0]   idx, idx_n;
    logic            tx_start_n, frame_active_n;
    logic [7:0]      tx_data_n;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]      checksum, checksum_n;
    logic            chk_sent, chk_sent_n;
`endif

    assign full = (fifo_count == DEPTH_C);
    assign pop  = (state == SMP);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push = sample_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (sample_valid && !push)
                overflow <= 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            frame_active <= 1'b0;
            idx          <= '0;
`ifdef FRAME_CHECKSUM_EN
            checksum     <= 8'h00;
            chk_sent     <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            tx_start     <= tx_start_n;
            tx_data      <= tx_data_n;
            frame_active <= frame_active_n;
            idx          <= idx_n;
`ifdef FRAME_CHECKSUM_EN
            checksum     <= checksum_n;
            chk_sent     <= chk_sent_n;
`endif
        end
    end

    always_comb begin
        state_n        = state;
        tx_start_n     = 1'b0;
        tx_data_n      = tx_data;
        frame_active_n = frame_active;
        idx_n          = idx;
`ifdef FRAME_CHECKSUM_EN
        checksum_n     = checksum;
        chk_sent_n     = chk_sent;
`endif
        case (state)
            IDLE: begin
                if (enable && fifo_count >= LEN_CNT) begin
                    state_n = HDR;
                    idx_n   = '0;
`ifdef FRAME_CHECKSUM_EN
                    checksum_n = 8'h00;
                    chk_sent_n = 1'b0;
`endif
                end
            end
            HDR: begin
                tx_data_n      = HEADER;
                tx_start_n     = 1'b1;
                frame_active_n = 1'b1;
                state_n        = WAIT;
            end
            SMP: begin
                tx_data_n  = mem[rd_ptr];
                tx_start_n = 1'b1;
                idx_n      = idx + 1'b1;
`ifdef FRAME_CHECKSUM_EN
                checksum_n = checksum + mem[rd_ptr];
`endif
                state_n    = WAIT;
            end
`ifdef FRAME_CHECKSUM_EN
            CHK: begin
                tx_data_n  = checksum;
                tx_start_n = 1'b1;
                chk_sent_n = 1'b1;
                state_n    = WAIT;
            end
`endif
            WAIT: begin
                if (tx_done) begin
                    // idx is still 0 after the header, so the header also lands here.
                    if (idx < LEN_IDX)
                        state_n = SMP;
`ifdef FRAME_CHECKSUM_EN
                    else if (!chk_sent)
                        state_n = CHK;
`endif
                    else begin
                        state_n        = IDLE;
                        frame_active_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
